// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: per-stage enable/flush,
// load-use interlock, EX redirect (with a pending state while a fetch is in flight), LSU freeze.
module pipe_hazard_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_AW-1:0]     id_rs1,
  input  logic [REG_AW-1:0]     id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_AW-1:0]     ex_rd,
  input  logic                  ex_is_load,
  input  logic                  ex_redirect,
  input  logic [DATA_WIDTH-1:0] ex_target,
  input  logic                  ifu_ready,
  input  logic                  lsu_busy,
  output logic                  pc_en,
  output logic                  pc_sel_redirect,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_en,
  output logic                  id_ex_flush,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  typedef enum logic {RUN = 1'b0, REDIR_PEND = 1'b1} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_pend_pc;
  logic [CNT_W-1:0]      r_stall_cnt;
  logic [CNT_W-1:0]      r_flush_cnt;
  logic                  w_load_use;

  assign w_load_use = ex_is_load && (ex_rd != '0) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));

  always_comb begin
    pc_en           = 1'b1;
    pc_sel_redirect = 1'b0;
    redirect_pc     = '0;
    if_id_en        = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_en        = 1'b1;
    id_ex_flush     = 1'b0;
    ex_mem_en       = 1'b1;
    mem_wb_en       = 1'b1;
    if (!rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      if (lsu_busy) begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        mem_wb_en = 1'b0;
      end else if (r_state == REDIR_PEND || ex_redirect) begin
        // Pending state ignores ex_redirect: EX holds a bubble while waiting.
        if (ifu_ready) begin
          pc_sel_redirect = 1'b1;
          redirect_pc     = (r_state == REDIR_PEND) ? r_pend_pc : ex_target;
          if_id_flush     = 1'b1;
          id_ex_flush     = 1'b1;
        end else begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end else if (w_load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end else if (!ifu_ready) begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
      end
      // A bubble must actually be written, so a flush forces its register enable.
      if (if_id_flush) if_id_en = 1'b1;
      if (id_ex_flush) id_ex_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= RUN;
      r_pend_pc   <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_en)          r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (pc_sel_redirect) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if (!lsu_busy) begin
        if (r_state == RUN) begin
          if (ex_redirect && !ifu_ready) begin
            r_pend_pc <= ex_target;
            r_state   <= REDIR_PEND;
          end
        end else if (ifu_ready) begin
          r_state <= RUN;
        end
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed cycles push expected outputs,
// a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_used, id_rs2_used, ex_is_load, ex_redirect, ifu_ready, lsu_busy;
  logic [31:0] ex_target;
  logic        pc_en, pc_sel_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic        ex_mem_en, mem_wb_en;
  logic [31:0] redirect_pc, stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.DATA_WIDTH(32), .REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect), .ex_target(ex_target),
    .ifu_ready(ifu_ready), .lsu_busy(lsu_busy),
    .pc_en(pc_en), .pc_sel_redirect(pc_sel_redirect), .redirect_pc(redirect_pc),
    .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_en(id_ex_en),
    .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // {pc_en, pc_sel_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}
  localparam logic [7:0] C_NORM   = 8'b1010_1011;
  localparam logic [7:0] C_RST    = 8'b0001_0100;
  localparam logic [7:0] C_FREEZE = 8'b0000_0000;
  localparam logic [7:0] C_REDIR  = 8'b1111_1111;
  localparam logic [7:0] C_HOLD   = 8'b0000_1111;
  localparam logic [7:0] C_FWAIT  = 8'b0011_1011;

  typedef struct {
    logic [7:0]  ctrl;
    logic [31:0] rpc;
    logic [31:0] stall;
    logic [31:0] flush;
    bit          cv;
    string       name;
  } exp_t;

  typedef struct {
    logic        rst;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, ld, redir, rdy, busy;
    logic [31:0] tgt;
  } stim_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b1; s.rs1 = '0; s.rs2 = '0; s.rd = '0;
    s.u1 = 1'b0; s.u2 = 1'b0; s.ld = 1'b0; s.redir = 1'b0;
    s.rdy = 1'b1; s.busy = 1'b0; s.tgt = '0;
    return s;
  endfunction

  task automatic step(input stim_t s, input logic [7:0] ctrl, input logic [31:0] rpc,
                      input bit cv, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst = s.rst; id_rs1 = s.rs1; id_rs2 = s.rs2; ex_rd = s.rd;
    id_rs1_used = s.u1; id_rs2_used = s.u2; ex_is_load = s.ld;
    ex_redirect = s.redir; ex_target = s.tgt; ifu_ready = s.rdy; lsu_busy = s.busy;
    e.ctrl = ctrl; e.rpc = rpc; e.stall = m_stall; e.flush = m_flush; e.cv = cv; e.name = name;
    q.push_back(e);
    if (!s.rst) begin
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (!ctrl[7]) m_stall = m_stall + 32'd1;
      if (ctrl[6])  m_flush = m_flush + 32'd1;
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e = q.pop_front();
      act = {pc_en, pc_sel_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
             ex_mem_en, mem_wb_en};
      n_chk++;
      if (act !== e.ctrl) begin
        n_fail++;
        $display("FAIL %s ctrl: got %b expected %b", e.name, act, e.ctrl);
      end
      n_chk++;
      if (redirect_pc !== e.rpc) begin
        n_fail++;
        $display("FAIL %s redirect_pc: got %h expected %h", e.name, redirect_pc, e.rpc);
      end
      if (e.cv) begin
        n_chk++;
        if (stall_cnt !== e.stall) begin
          n_fail++;
          $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, stall_cnt, e.stall);
        end
        n_chk++;
        if (flush_cnt !== e.flush) begin
          n_fail++;
          $display("FAIL %s flush_cnt: got %0d expected %0d", e.name, flush_cnt, e.flush);
        end
      end
    end
  end

  initial begin
    stim_t s;
    rst = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_is_load = 1'b0; ex_redirect = 1'b0; ex_target = '0; ifu_ready = 1'b1; lsu_busy = 1'b0;

    s = idle(); s.rst = 1'b0;
    step(s, C_RST, 32'h0, 1'b0, "reset0");
    step(s, C_RST, 32'h0, 1'b1, "reset1");
    step(idle(), C_NORM, 32'h0, 1'b1, "idle");

    // Load-use on rs2, then ex_rd=0 and unused-rs1 cases that must not stall
    s = idle(); s.ld = 1'b1; s.rd = 5'd5; s.rs2 = 5'd5; s.u2 = 1'b1;
    step(s, C_HOLD, 32'h0, 1'b1, "loaduse_rs2");
    step(idle(), C_NORM, 32'h0, 1'b1, "after_loaduse");
    s = idle(); s.ld = 1'b1; s.rd = 5'd0; s.rs2 = 5'd0; s.u2 = 1'b1;
    step(s, C_NORM, 32'h0, 1'b1, "loaduse_x0");
    s = idle(); s.ld = 1'b1; s.rd = 5'd7; s.rs1 = 5'd7; s.u1 = 1'b0;
    step(s, C_NORM, 32'h0, 1'b1, "rs1_unused");
    s.u1 = 1'b1;
    step(s, C_HOLD, 32'h0, 1'b1, "loaduse_rs1");

    // Redirect with fetch ready
    s = idle(); s.redir = 1'b1; s.tgt = 32'h8000_0040;
    step(s, C_REDIR, 32'h8000_0040, 1'b1, "redir_ready");
    step(idle(), C_NORM, 32'h0, 1'b1, "after_redir");

    s = idle(); s.rdy = 1'b0;
    step(s, C_FWAIT, 32'h0, 1'b1, "fetch_wait");

    // Redirect while fetch in flight; a second ex_redirect in REDIR_PEND is ignored
    s = idle(); s.redir = 1'b1; s.tgt = 32'h8000_0100; s.rdy = 1'b0;
    step(s, C_HOLD, 32'h0, 1'b1, "pend1");
    s.tgt = 32'h1234_5678;
    step(s, C_HOLD, 32'h0, 1'b1, "pend2_ignored");
    s = idle(); s.rdy = 1'b0;
    step(s, C_HOLD, 32'h0, 1'b1, "pend3");
    step(idle(), C_REDIR, 32'h8000_0100, 1'b1, "pend_fire");
    step(idle(), C_NORM, 32'h0, 1'b1, "after_pend");

    // lsu_busy freezes REDIR_PEND without losing pend_pc
    s = idle(); s.redir = 1'b1; s.tgt = 32'h8000_0200; s.rdy = 1'b0;
    step(s, C_HOLD, 32'h0, 1'b1, "pend_lsu");
    s = idle(); s.busy = 1'b1;
    for (int i = 0; i < 4; i++) step(s, C_FREEZE, 32'h0, 1'b1, "lsu_freeze");
    step(idle(), C_REDIR, 32'h8000_0200, 1'b1, "lsu_release_fire");
    step(idle(), C_NORM, 32'h0, 1'b1, "after_lsu");

    // Priority: lsu_busy over redirect over load-use
    s = idle(); s.busy = 1'b1; s.redir = 1'b1; s.tgt = 32'h8000_0300;
    s.ld = 1'b1; s.rd = 5'd9; s.rs1 = 5'd9; s.u1 = 1'b1;
    step(s, C_FREEZE, 32'h0, 1'b1, "prio_freeze1");
    step(s, C_FREEZE, 32'h0, 1'b1, "prio_freeze2");
    s.busy = 1'b0;
    step(s, C_REDIR, 32'h8000_0300, 1'b1, "prio_redir");
    step(idle(), C_NORM, 32'h0, 1'b1, "after_prio");

    // Reset in REDIR_PEND discards the pending redirect
    s = idle(); s.redir = 1'b1; s.tgt = 32'h8000_0400; s.rdy = 1'b0;
    step(s, C_HOLD, 32'h0, 1'b1, "pend_rst");
    s = idle(); s.rst = 1'b0;
    step(s, C_RST, 32'h0, 1'b1, "mid_reset");
    step(idle(), C_NORM, 32'h0, 1'b1, "post_reset");
    s = idle(); s.rdy = 1'b0;
    step(s, C_FWAIT, 32'h0, 1'b1, "post_reset_wait");
    step(idle(), C_NORM, 32'h0, 1'b1, "final");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
